// File: rtl/imem_loader.sv
// Boot-time program loader: length header + big-endian 16-bit payload + XOR checksum,
// written into instruction memory; core_run releases fetch once the image verifies.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_run,
    output logic              load_err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_CSUM    = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_e;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_e              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          csum_q, csum_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                run_q, run_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic                ready_q, ready_d;

    logic                accept_s;
    logic [15:0]         len_n_s;
    logic [ADDR_W:0]     words_inc_s;

    // Next-state and next-output computation for the loader FSM
    always_comb begin
        accept_s    = in_valid & ready_q;
        len_n_s     = {len_q[15:8], in_data};
        words_inc_s = words_q + {{ADDR_W{1'b0}}, 1'b1};
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        words_d     = words_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        run_d       = run_q;
        err_d       = err_q;
        code_d      = code_q;
        if (accept_s) begin
            case (state_q)
                S_LEN_HI: begin
                    len_d   = {in_data, 8'h00};
                    csum_d  = csum_q ^ in_data;
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d  = len_n_s;
                    csum_d = csum_q ^ in_data;
                    if ((len_n_s == 16'd0) || ({1'b0, len_n_s} > MAX_WORDS)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    we_d    = 1'b1;
                    addr_d  = words_q[ADDR_W-1:0];
                    wdata_d = {hi_q, in_data};
                    words_d = words_inc_s;
                    csum_d  = csum_q ^ in_data;
                    // Counter is one wider than the address so N == 2**ADDR_W terminates cleanly
                    if (17'(words_inc_s) == {1'b0, len_q}) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_CSUM: begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                        run_d   = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LEN_HI;
            len_q   <= 16'd0;
            hi_q    <= 8'd0;
            csum_q  <= 8'd0;
            words_q <= '0;
            addr_q  <= '0;
            wdata_q <= 16'd0;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            run_q   <= run_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready     = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_run     = run_q;
    assign load_err     = err_q;
    assign err_code     = code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-level reference model, table of scenarios,
// hand-written corner sequences and randomized streams with bubbles.
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          core_run;
    logic          load_err;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_run(core_run), .load_err(load_err),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [AW:0]   w;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        bit          bad;
        int          mode;
        int          code;
        bit          run;
        int          words;
    } vec_t;

    wr_t        wr_q[$];
    logic [7:0] rx_q[$];
    bit         lo_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle write-strobe timing: a write pulse follows exactly the acceptance of a low payload byte
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_q.delete();
            lo_pend = 1'b0;
        end else begin
            int idx;
            int n;
            chk("we_timing", {31'd0, imem_we}, {31'd0, lo_pend});
            if (imem_we) wr_q.push_back('{a: imem_addr, d: imem_wdata, w: words_loaded});
            lo_pend = 1'b0;
            if (in_valid && in_ready) begin
                rx_q.push_back(in_data);
                idx = rx_q.size() - 1;
                if (idx >= 3 && (idx % 2) == 1) begin
                    n = {rx_q[0], rx_q[1]};
                    if (n != 0 && n <= (1 << AW) && idx <= 2 * n + 1) lo_pend = 1'b1;
                end
            end
        end
    end

    // Reference model: what a complete stream must produce
    task automatic model(input logic [7:0] s[$], output wr_t e[$], output int code,
                         output bit run, output int words);
        int         n;
        logic [7:0] x;
        e.delete();
        n = {s[0], s[1]};
        if (n == 0 || n > (1 << AW)) begin
            code = 1; run = 1'b0; words = 0;
            return;
        end
        x = 8'd0;
        for (int i = 0; i < s.size() - 1; i++) x ^= s[i];
        for (int w = 0; w < n; w++)
            e.push_back('{a: AW'(w), d: {s[2 + 2 * w], s[3 + 2 * w]}, w: (AW + 1)'(w + 1)});
        words = n;
        if (s[s.size() - 1] == x) begin
            code = 0; run = 1'b1;
        end else begin
            code = 2; run = 1'b0;
        end
    endtask

    task automatic build(input logic [15:0] len, input bit bad, output logic [7:0] s[$]);
        logic [7:0] x;
        s.delete();
        s.push_back(len[15:8]);
        s.push_back(len[7:0]);
        if (len == 16'd0 || len > 16'(1 << AW)) return;
        for (int i = 0; i < 2 * len; i++) s.push_back(8'($urandom));
        x = 8'd0;
        foreach (s[i]) x ^= s[i];
        if (bad) x ^= 8'($urandom_range(1, 255));
        s.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_run", {31'd0, core_run}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Drive bytes; mode 0 full rate, 1 toggling valid, 2 random gaps, 3 three-cycle gap before low bytes
    task automatic send(input logic [7:0] s[$], input int mode);
        for (int i = 0; i < s.size(); i++) begin
            int gap;
            bit acc;
            gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) :
                  (mode == 3 && i >= 3 && (i % 2) == 1) ? 3 : 0;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = s[i];
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_check(input logic [7:0] s[$], input int mode, input string tag);
        wr_t           e[$];
        int            code;
        int            words;
        bit            run;
        logic [AW-1:0] a0;
        logic [15:0]   d0;
        int            nw;
        do_reset();
        wr_q.delete();
        send(s, mode);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        model(s, e, code, run, words);
        chk({tag, "_code"}, 32'(err_code), 32'(code));
        chk({tag, "_err"}, {31'd0, load_err}, {31'd0, code != 0});
        chk({tag, "_run"}, {31'd0, core_run}, {31'd0, run});
        chk({tag, "_words"}, 32'(words_loaded), 32'(words));
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < wr_q.size(); i++) begin
            if (wr_q[i] != e[i]) begin
                chk({tag, "_wr_addr"}, 32'(wr_q[i].a), 32'(e[i].a));
                chk({tag, "_wr_data"}, 32'(wr_q[i].d), 32'(e[i].d));
                chk({tag, "_wr_cnt"}, 32'(wr_q[i].w), 32'(e[i].w));
            end
        end
        // Terminal state must ignore further traffic
        a0 = imem_addr;
        d0 = imem_wdata;
        nw = wr_q.size();
        in_valid = 1'b1;
        repeat (6) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk({tag, "_post_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_post_writes"}, 32'(wr_q.size()), 32'(nw));
        chk({tag, "_post_state"}, {imem_addr, imem_wdata, core_run, load_err, err_code},
            {a0, d0, run, code != 0, 2'(code)});
        chk({tag, "_post_words"}, 32'(words_loaded), 32'(words));
    endtask

    initial begin
        logic [7:0] nom[$];
        logic [7:0] part[$];
        logic [7:0] s[$];
        vec_t       tbl[8];

        tbl[0] = '{16'h0000, 1'b0, 0, 1, 1'b0, 0};
        tbl[1] = '{16'h0101, 1'b0, 0, 1, 1'b0, 0};
        tbl[2] = '{16'hFFFF, 1'b0, 2, 1, 1'b0, 0};
        tbl[3] = '{16'h0100, 1'b0, 0, 0, 1'b1, 256};
        tbl[4] = '{16'h0001, 1'b0, 1, 0, 1'b1, 1};
        tbl[5] = '{16'h0003, 1'b1, 3, 2, 1'b0, 3};
        tbl[6] = '{16'h0005, 1'b0, 2, 0, 1'b1, 5};
        tbl[7] = '{16'h0100, 1'b1, 1, 2, 1'b0, 256};

        nom = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};

        // Nominal at full rate, core_run timing around the checksum byte
        do_reset();
        wr_q.delete();
        send(nom, 0);
        chk("nom_run_before_csum", {31'd0, core_run}, 32'd0);
        send('{8'h42}, 0);
        chk("nom_run", {31'd0, core_run}, 32'd1);
        chk("nom_ready", {31'd0, in_ready}, 32'd0);
        chk("nom_err", {31'd0, load_err}, 32'd0);
        chk("nom_words", 32'(words_loaded), 32'd2);
        chk("nom_nwrites", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            chk("nom_w0", {16'(wr_q[0].a), wr_q[0].d}, 32'h0000_1234);
            chk("nom_w1", {16'(wr_q[1].a), wr_q[1].d}, 32'h0001_ABCD);
        end

        // Checksum mismatch
        do_reset();
        wr_q.delete();
        send(nom, 0);
        send('{8'h43}, 0);
        chk("csum_run", {31'd0, core_run}, 32'd0);
        chk("csum_err", {31'd0, load_err}, 32'd1);
        chk("csum_code", 32'(err_code), 32'd2);
        chk("csum_ready", {31'd0, in_ready}, 32'd0);
        chk("csum_nwrites", 32'(wr_q.size()), 32'd2);

        // Reset after the first payload byte discards the partial word
        do_reset();
        wr_q.delete();
        part = '{8'h00, 8'h02, 8'h12};
        send(part, 0);
        do_reset();
        chk("midrst_nwrites", 32'(wr_q.size()), 32'd0);
        s = nom;
        s.push_back(8'h42);
        run_check(s, 0, "midrst_resend");
        run_check(s, 1, "nom_toggle");
        run_check(s, 3, "nom_gap3");

        foreach (tbl[i]) begin
            build(tbl[i].len, tbl[i].bad, s);
            run_check(s, tbl[i].mode, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_code", i), 32'(err_code), 32'(tbl[i].code));
            chk($sformatf("tbl%0d_run", i), {31'd0, core_run}, {31'd0, tbl[i].run});
            chk($sformatf("tbl%0d_words", i), 32'(words_loaded), 32'(tbl[i].words));
        end

        for (int r = 0; r < 30; r++) begin
            logic [15:0] len;
            if ($urandom_range(0, 9) == 0)
                len = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(257, 65535));
            else
                len = 16'($urandom_range(1, 12));
            build(len, ($urandom_range(0, 2) == 0), s);
            run_check(s, int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
